// File: rtl/multiport_fifo.sv
// multiport_fifo: single-clock FIFO that accepts 0..NW entries and returns
// 0..NR entries per cycle. Each write and each read is all-or-nothing and is
// judged only against the occupancy registered at the start of the cycle.
// Read results come out of a register one cycle after an accepted read.
// Optional feature: define MULTIPORT_FIFO_FLUSH_EN to add a synchronous
// flush input. Flush empties the FIFO like reset does, but read_data keeps
// its last value.
module multiport_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 16,
  parameter int  NW    = 2,
  parameter int  NR    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef MULTIPORT_FIFO_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic [$clog2(NW+1)-1:0]      write_cnt,
  input  T     [NW-1:0]                write_data,
  input  logic [$clog2(NR+1)-1:0]      read_cnt,
  output T     [NR-1:0]                read_data,
  output logic [NR-1:0]                read_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   free_slots
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Add an offset to a pointer and wrap it modulo DEPTH. DEPTH need not be
  // a power of two. The offset is at most DEPTH, so one subtraction is
  // enough.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // Storage and control state
  T                r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_free;
  logic            r_full;
  logic            r_empty;
  T     [NR-1:0]   r_read_data_p1;
  logic [NR-1:0]   r_vld_p1;

  // Combinational decisions for the current cycle
  logic            w_flush;
  logic            w_wr_ok;
  logic            w_rd_ok;
  logic            w_wr_go;
  logic            w_rd_go;
  logic [PW-1:0]   w_wr_idx [NW];
  logic [PW-1:0]   w_rd_idx [NR];
  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_free_nxt;

`ifdef MULTIPORT_FIFO_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Acceptance uses only registered occupancy. A zero request is not an
  // operation, and a request larger than the lane count is rejected.
  always_comb begin
    w_wr_ok = (write_cnt != '0) && (int'(write_cnt) <= NW) &&
              (int'(write_cnt) <= int'(r_free));
    w_rd_ok = (read_cnt != '0) && (int'(read_cnt) <= NR) &&
              (int'(read_cnt) <= int'(r_count));
    w_wr_go = w_wr_ok && !reset && !w_flush;
    w_rd_go = w_rd_ok && !reset && !w_flush;
  end

  // Per-lane memory addresses. A multi-lane access may wrap past DEPTH-1.
  always_comb begin
    for (int i = 0; i < NW; i++) w_wr_idx[i] = wrap_add(r_wptr, i);
    for (int i = 0; i < NR; i++) w_rd_idx[i] = wrap_add(r_rptr, i);
  end

  // Next occupancy: accepted writes and reads both apply in the same cycle.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_ok) w_count_nxt = w_count_nxt + CW'(write_cnt);
    if (w_rd_ok) w_count_nxt = w_count_nxt - CW'(read_cnt);
    w_free_nxt  = CW'(DEPTH) - w_count_nxt;
  end

  // Storage write. Data cells are not reset; count and pointers decide
  // which cells are live.
  always_ff @(posedge clk) begin
    if (w_wr_go) begin
      for (int i = 0; i < NW; i++) begin
        if (i < int'(write_cnt)) r_mem[w_wr_idx[i]] <= write_data[i];
      end
    end
  end

  // Pointers, occupancy and flags. Reset and flush return these to empty.
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_free  <= CW'(DEPTH);
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr_ok) r_wptr <= wrap_add(r_wptr, int'(write_cnt));
      if (w_rd_ok) r_rptr <= wrap_add(r_rptr, int'(read_cnt));
      r_count <= w_count_nxt;
      r_free  <= w_free_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // ---- stage p1: registered read result ----
  // read_valid pulses for one cycle after each accepted read.
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_vld_p1 <= '0;
    end else begin
      for (int i = 0; i < NR; i++) r_vld_p1[i] <= w_rd_ok && (i < int'(read_cnt));
    end
  end

  // Read lanes are cleared by reset. Flush and rejected reads leave them
  // unchanged. Lanes beyond the accepted count also keep their old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_data_p1 <= '0;
    end else if (w_rd_go) begin
      for (int i = 0; i < NR; i++) begin
        if (i < int'(read_cnt)) r_read_data_p1[i] <= r_mem[w_rd_idx[i]];
      end
    end
  end

  assign read_data  = r_read_data_p1;
  assign read_valid = r_vld_p1;
  assign count      = r_count;
  assign free_slots = r_free;
  assign full       = r_full;
  assign empty      = r_empty;

endmodule

// File: tb/tb_multiport_fifo.sv
// Directed plus short random stimulus for multiport_fifo with DEPTH=16,
// NW=2 and NR=2. A queue-based reference model computes the expected
// results. Entries read out are pushed to a scoreboard queue and popped when
// the DUT presents them.
module tb_multiport_fifo;
  localparam int DEPTH = 16;
  localparam int NW    = 2;
  localparam int NR    = 2;

  logic                               clk;
  logic                               reset;
`ifdef MULTIPORT_FIFO_FLUSH_EN
  logic                               flush;
`endif
  logic [$clog2(NW+1)-1:0]            write_cnt;
  logic [NW-1:0][31:0]                write_data;
  logic [$clog2(NR+1)-1:0]            read_cnt;
  logic [NR-1:0][31:0]                read_data;
  logic [NR-1:0]                      read_valid;
  logic [$clog2(DEPTH+1)-1:0]         count;
  logic                               full;
  logic                               empty;
  logic [$clog2(DEPTH+1)-1:0]         free_slots;

  multiport_fifo #(.T(logic [31:0]), .DEPTH(DEPTH), .NW(NW), .NR(NR)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MULTIPORT_FIFO_FLUSH_EN
    .flush      (flush),
`endif
    .write_cnt  (write_cnt),
    .write_data (write_data),
    .read_cnt   (read_cnt),
    .read_data  (read_data),
    .read_valid (read_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .free_slots (free_slots)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          ncmp = 0;
  int          nbad = 0;
  logic [31:0] mq[$];       // reference FIFO contents
  logic [31:0] sb_q[$];     // scoreboard: entries expected on read_data
  logic [31:0] last_rd [NR];
  int          ctr = 1000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, update the model, then check 1 ns after
  // the rising edge.
  task automatic step(input int wc, input logic [31:0] d0, input logic [31:0] d1,
                      input int rc, input bit rst_in, input bit fl_in);
    int          sz;
    bit          wok;
    bit          rok;
    logic [NR-1:0] exp_vld;
    logic [31:0] v;
    @(negedge clk);
    reset         = rst_in;
`ifdef MULTIPORT_FIFO_FLUSH_EN
    flush         = fl_in;
`endif
    write_cnt     = wc[1:0];
    write_data[0] = d0;
    write_data[1] = d1;
    read_cnt      = rc[1:0];
    sz      = mq.size();
    wok     = (wc >= 1) && (wc <= NW) && (wc <= DEPTH - sz);
    rok     = (rc >= 1) && (rc <= NR) && (rc <= sz);
    exp_vld = '0;
    if (rst_in) begin
      mq.delete();
      for (int i = 0; i < NR; i++) last_rd[i] = '0;
    end else if (fl_in) begin
      mq.delete();
    end else begin
      if (rok) begin
        for (int i = 0; i < rc; i++) begin
          v = mq.pop_front();
          sb_q.push_back(v);
          last_rd[i] = v;
          exp_vld[i] = 1'b1;
        end
      end
      if (wok) begin
        mq.push_back(d0);
        if (wc == 2) mq.push_back(d1);
      end
    end
    @(posedge clk);
    #1;
    chk("read_valid", 64'(read_valid), 64'(exp_vld));
    for (int i = 0; i < NR; i++) begin
      if (exp_vld[i]) begin
        if (sb_q.size() == 0) chk("scoreboard_underrun", 64'(1), 64'(0));
        else chk($sformatf("read_data[%0d]", i), 64'(read_data[i]), 64'(sb_q.pop_front()));
      end else begin
        chk($sformatf("read_data_hold[%0d]", i), 64'(read_data[i]), 64'(last_rd[i]));
      end
    end
    chk("count", 64'(count), 64'(mq.size()));
    chk("free_slots", 64'(free_slots), 64'(DEPTH - mq.size()));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
  endtask

  task automatic wstep(input int wc, input int rc);
    step(wc, ctr, ctr + 1, rc, 1'b0, 1'b0);
    ctr += 2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int v;
    int wc;
    int rc;
    int guard;
    bit fl;
    reset = 1'b1;
`ifdef MULTIPORT_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    write_cnt  = '0;
    write_data = '0;
    read_cnt   = '0;
    for (int i = 0; i < NR; i++) last_rd[i] = '0;

    // reset state, with requests ignored during reset
    step(0, 0, 0, 0, 1'b1, 1'b0);
    step(2, 32'h11, 32'h22, 2, 1'b1, 1'b0);

    // fill: 8 writes of 2 reach full, and a 9th write is rejected
    for (int i = 0; i < 8; i++) wstep(2, 0);
    wstep(2, 0);
    // an oversize read is rejected; then drain
    wstep(0, 3);
    for (int i = 0; i < 8; i++) wstep(0, 2);
    // an oversize write on an empty FIFO is rejected; an underflow read too
    wstep(3, 0);
    wstep(0, 1);

    // oversize at count 15: a write of 2 is rejected, then a write of 1 gives full
    for (int i = 0; i < 7; i++) wstep(2, 0);
    wstep(1, 0);
    wstep(2, 0);
    wstep(1, 0);
    for (int i = 0; i < 8; i++) wstep(0, 2);

    // move pointers to an odd offset so 2-wide reads straddle 15 -> 0
    wstep(1, 0);
    wstep(0, 1);

    // wrap order: write 1..40 while reading 2 whenever count >= 2
    v = 1;
    guard = 0;
    while ((v <= 40 || mq.size() > 0) && guard < 200) begin
      wc = (v <= 40) ? 1 : 0;
      if (mq.size() >= 2) rc = 2;
      else if (v > 40 && mq.size() == 1) rc = 1;
      else rc = 0;
      step(wc, v, 0, rc, 1'b0, 1'b0);
      if (wc == 1) v++;
      guard++;
    end
    chk("wrap_drain_done", 64'(mq.size()), 64'(0));

    // simultaneous: count 1, write 2 and read 2 -> read rejected, count 3
    wstep(1, 0);
    wstep(2, 2);
    wstep(0, 2);
    wstep(0, 1);

    // reset mid-stream at count 9 with a read issued in the reset cycle
    for (int i = 0; i < 4; i++) wstep(2, 0);
    wstep(1, 0);
    step(2, 32'hdead, 32'hbeef, 2, 1'b1, 1'b0);
    wstep(2, 0);
    wstep(0, 2);

`ifdef MULTIPORT_FIFO_FLUSH_EN
    // flush at count 5 with a same-cycle write; flushed data never appears
    wstep(2, 0);
    wstep(2, 0);
    wstep(1, 0);
    step(1, 32'hf00d, 0, 0, 1'b0, 1'b1);
    wstep(2, 0);
    wstep(0, 2);
`endif

    // short random mix
    for (int i = 0; i < 250; i++) begin
      fl = 1'b0;
`ifdef MULTIPORT_FIFO_FLUSH_EN
      fl = ($urandom_range(0, 39) == 0);
`endif
      step($urandom_range(0, 3), $urandom, $urandom, $urandom_range(0, 3),
           ($urandom_range(0, 79) == 0), fl);
    end

    @(negedge clk);
    write_cnt = '0;
    read_cnt  = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/multiport_fifo.md
MULTIPORT_FIFO -- requirements
Module: multiport_fifo

Interface
REQ-001 Parameter T, default logic [31:0]: entry type.
REQ-002 Parameter DEPTH, default 16: entries; any integer >= max(NW,NR) and >= 2; power of two not required.
REQ-003 Parameter NW, default 2: write lanes per cycle, >= 1.
REQ-004 Parameter NR, default 2: read lanes per cycle, >= 1.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 write_cnt  in  $clog2(NW+1)  number of entries offered this cycle, taken from lanes 0..write_cnt-1.
REQ-008 write_data  in  NW x T  write lanes; lane 0 is oldest.
REQ-009 read_cnt  in  $clog2(NR+1)  number of entries requested this cycle.
REQ-010 read_data  out  NR x T  registered read lanes; lane 0 is oldest.
REQ-011 read_valid  out  NR  registered per-lane valid for read_data.
REQ-012 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-013 full  out  1  count == DEPTH.
REQ-014 empty  out  1  count == 0.
REQ-015 free_slots  out  $clog2(DEPTH+1)  DEPTH - count.

Function
REQ-016 Acceptance decisions in a cycle shall use only the occupancy registered at the start of that cycle.
- Same-cycle pops do not create write space.
- Same-cycle pushes do not satisfy reads.
REQ-017 Write shall be all-or-nothing.
- write_cnt <= free_slots: all lanes 0..write_cnt-1 are stored in lane order at consecutive positions.
- Otherwise: nothing is stored.
REQ-018 Read shall be all-or-nothing.
- read_cnt <= count: the oldest read_cnt entries are removed.
- Otherwise: nothing is removed.
REQ-019 Read latency shall be one cycle.
- After an accepted read of k entries: read_data[0..k-1] hold those entries oldest-first, read_valid[i] = (i < k).
- After a rejected or zero read: read_valid shall be all zero; read_data holds its previous value.
REQ-020 Next count shall equal count + accepted writes - accepted reads; simultaneous accepted read and write shall both apply.
REQ-021 Read and write pointers shall wrap modulo DEPTH, including a single multi-lane operation that straddles the wrap point.
REQ-022 full, empty, count and free_slots shall be registered and consistent with each other in every cycle.
REQ-023 Entry order shall be strict FIFO across all lanes and cycles.
REQ-024 write_cnt > NW or read_cnt > NR shall be treated as a rejected operation.

Reset
REQ-025 While reset is high at a clock edge:
- pointers = 0, count = 0, empty = 1, full = 0, free_slots = DEPTH, read_valid = 0, read_data = 0.
- All writes and reads in that cycle are ignored.
REQ-026 Reset asserted mid-operation shall discard all stored entries and any pending read result in the same edge.

Configuration
REQ-027 Macro MULTIPORT_FIFO_FLUSH_EN.
- Defined: adds input flush (1 bit).
- flush high at an edge has the same effect as REQ-025 on pointers, count, flags and read_valid, but read_data is held.
- flush takes priority over same-cycle writes and reads.
- Undefined: no flush port, and behaviour is otherwise identical.

Verification
REQ-028 Fill: DEPTH=16, NW=2; 8 cycles of write_cnt=2 -> full=1, count=16; a 9th write of 2 is rejected and count stays 16.
REQ-029 Oversize: count=15, write_cnt=2 -> nothing stored, count stays 15; next cycle write_cnt=1 -> full=1.
REQ-030 Wrap order: write 1..40 sequentially while reading 2 per cycle whenever count >= 2 -> read_data yields 1..40 in order, with a read straddling index 15->0 correct.
REQ-031 Simultaneous: count=1, write_cnt=2, read_cnt=2 -> read rejected, write accepted, count=3, read_valid=00 next cycle.
REQ-032 Reset mid-stream: count=9 with read_cnt=2 issued in the reset cycle -> next cycle count=0, empty=1, read_valid=00.
REQ-033 With MULTIPORT_FIFO_FLUSH_EN: count=5, flush=1 with write_cnt=1 -> count=0, empty=1; the flushed data is never read.
